// File: rtl/mccu_pkg.sv
// mccu_pkg: shared encodings for the multicycle control unit.
// State codes, MIPS op/func constants, ALU control codes, datapath
// select codes and the decoded-instruction flag struct.
package mccu_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  // opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function fields
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // ALU control; the don't-care msb of the x-codes is driven 0
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  // ALU B operand select
  localparam logic [1:0] ASRCB_REG  = 2'b00;
  localparam logic [1:0] ASRCB_FOUR = 2'b01;
  localparam logic [1:0] ASRCB_IMM  = 2'b10;
  localparam logic [1:0] ASRCB_BR   = 2'b11;

  // PC source select
  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_TGT = 2'b01;
  localparam logic [1:0] PCS_RS  = 2'b10;
  localparam logic [1:0] PCS_JMP = 2'b11;

  // one-hot decoded instruction
  typedef struct packed {
    logic i_add, i_sub, i_and, i_or, i_xor;
    logic i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lui;
    logic i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
  } inst_t;

  // ALU operation used during the execute state
  function automatic logic [3:0] exe_aluc(input inst_t i);
    logic [3:0] c;
    c = ALUC_ADD;
    if (i.i_sub | i.i_beq | i.i_bne) c = ALUC_SUB;
    if (i.i_and | i.i_andi)          c = ALUC_AND;
    if (i.i_or  | i.i_ori)           c = ALUC_OR;
    if (i.i_xor | i.i_xori)          c = ALUC_XOR;
    if (i.i_lui)                     c = ALUC_LUI;
    if (i.i_sll)                     c = ALUC_SLL;
    if (i.i_srl)                     c = ALUC_SRL;
    if (i.i_sra)                     c = ALUC_SRA;
    return c;
  endfunction

endpackage

// File: rtl/mccu_decode.sv
// mccu_decode: purely combinational op/func decoder producing one-hot
// instruction flags; anything outside the supported subset raises illegal.
module mccu_decode
  import mccu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output inst_t      inst,
  output logic       illegal
);

  // decode the opcode, and the function field for R-type
  always_comb begin
    inst    = '0;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  inst.i_add = 1'b1;
          FN_SUB:  inst.i_sub = 1'b1;
          FN_AND:  inst.i_and = 1'b1;
          FN_OR:   inst.i_or  = 1'b1;
          FN_XOR:  inst.i_xor = 1'b1;
          FN_SLL:  inst.i_sll = 1'b1;
          FN_SRL:  inst.i_srl = 1'b1;
          FN_SRA:  inst.i_sra = 1'b1;
          FN_JR:   inst.i_jr  = 1'b1;
          default: illegal    = 1'b1;
        endcase
      end
      OP_ADDI: inst.i_addi = 1'b1;
      OP_ANDI: inst.i_andi = 1'b1;
      OP_ORI:  inst.i_ori  = 1'b1;
      OP_XORI: inst.i_xori = 1'b1;
      OP_LUI:  inst.i_lui  = 1'b1;
      OP_LW:   inst.i_lw   = 1'b1;
      OP_SW:   inst.i_sw   = 1'b1;
      OP_BEQ:  inst.i_beq  = 1'b1;
      OP_BNE:  inst.i_bne  = 1'b1;
      OP_J:    inst.i_j    = 1'b1;
      OP_JAL:  inst.i_jal  = 1'b1;
      default: illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/mccu_fsm.sv
// mccu_fsm: multicycle control unit (IF/ID/EXE/MEM/WB) for the MIPS subset.
// Outputs are combinational from state, op, func and z. Write enables are
// gated by clrn so nothing writes while reset is asserted.
// Optional build macro MCCU_MEMWAIT_EN: fetch and memory states wait for
// mem_rdy; without it mem_rdy is ignored.
module mccu_fsm
  import mccu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             z,
  input  logic             mem_rdy,
  output logic             wpc,
  output logic             wir,
  output logic             wmem,
  output logic             wreg,
  output logic             iord,
  output logic             regrt,
  output logic             m2reg,
  output logic             jal,
  output logic             shift,
  output logic             sext,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [3:0]       aluc,
  output logic [1:0]       pcsource,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] icount
);

  state_t state_q, state_nx;
  inst_t  inst;
  logic   illegal;
  logic   mem_ok;
  logic   wpc_r, wir_r, wmem_r, wreg_r;

  mccu_decode u_dec (
    .op      (op),
    .func    (func),
    .inst    (inst),
    .illegal (illegal)
  );

`ifdef MCCU_MEMWAIT_EN
  assign mem_ok = mem_rdy;
`else
  logic unused_mem_rdy;
  assign unused_mem_rdy = mem_rdy;
  assign mem_ok = 1'b1;
`endif

  // instruction classes shared by next-state and output logic
  logic is_jump, is_branch, is_mem, is_shift, imm_src, use_sext, wr_rt;
  assign is_jump   = inst.i_j | inst.i_jal | inst.i_jr;
  assign is_branch = inst.i_beq | inst.i_bne;
  assign is_mem    = inst.i_lw | inst.i_sw;
  assign is_shift  = inst.i_sll | inst.i_srl | inst.i_sra;
  assign wr_rt     = inst.i_addi | inst.i_andi | inst.i_ori | inst.i_xori |
                     inst.i_lui | inst.i_lw;
  assign imm_src   = wr_rt | inst.i_sw;
  assign use_sext  = inst.i_addi | is_mem | is_branch;

  // state register; reset lands in fetch
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= S_IF;
    else       state_q <= state_nx;
  end

  // retired-instruction counter: every return to fetch retires one
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                                icount <= '0;
    else if (state_nx == S_IF && state_q != S_IF) icount <= icount + 1'b1;
  end

  // next-state selection
  always_comb begin
    state_nx = S_IF;
    case (state_q)
      S_IF:  state_nx = mem_ok ? S_ID : S_IF;
      S_ID:  state_nx = (is_jump || illegal) ? S_IF : S_EXE;
      S_EXE: begin
        if (is_branch)   state_nx = S_IF;
        else if (is_mem) state_nx = S_MEM;
        else             state_nx = S_WB;
      end
      S_MEM: begin
        if (!mem_ok)         state_nx = S_MEM;
        else if (inst.i_lw)  state_nx = S_WB;
        else                 state_nx = S_IF;
      end
      S_WB:    state_nx = S_IF;
      default: state_nx = S_IF;
    endcase
  end

  // per-state datapath controls
  always_comb begin
    wpc_r    = 1'b0;
    wir_r    = 1'b0;
    wmem_r   = 1'b0;
    wreg_r   = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    shift    = 1'b0;
    sext     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = ASRCB_REG;
    aluc     = ALUC_ADD;
    pcsource = PCS_ALU;
    case (state_q)
      S_IF: begin
        alusrcb = ASRCB_FOUR;
        wpc_r   = mem_ok;
        wir_r   = mem_ok;
      end
      S_ID: begin
        // branch target PC+4+(offset<<2) is formed here, so the offset
        // must already be sign-extended
        alusrcb = ASRCB_BR;
        sext    = is_branch;
        if (inst.i_j || inst.i_jal) begin
          pcsource = PCS_JMP;
          wpc_r    = 1'b1;
        end
        if (inst.i_jal) begin
          wreg_r = 1'b1;
          jal    = 1'b1;
        end
        if (inst.i_jr) begin
          pcsource = PCS_RS;
          wpc_r    = 1'b1;
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        shift   = is_shift;
        alusrcb = imm_src ? ASRCB_IMM : ASRCB_REG;
        sext    = use_sext;
        aluc    = exe_aluc(inst);
        if (is_branch) begin
          pcsource = PCS_TGT;
          wpc_r    = (inst.i_beq & z) | (inst.i_bne & ~z);
        end
      end
      S_MEM: begin
        iord   = 1'b1;
        wmem_r = inst.i_sw;
      end
      S_WB: begin
        wreg_r = 1'b1;
        regrt  = wr_rt;
        m2reg  = inst.i_lw;
      end
      default: ;
    endcase
  end

  assign wpc   = wpc_r  & clrn;
  assign wir   = wir_r  & clrn;
  assign wmem  = wmem_r & clrn;
  assign wreg  = wreg_r & clrn;
  assign state = state_q;

endmodule

// File: tb/tb_mccu_fsm.sv
// tb_mccu_fsm: directed bench for mccu_fsm (built with CNT_W=4 so the
// counter wrap is reachable). Inputs change 1ns after the rising edge and
// outputs are checked in the same window.
module tb_mccu_fsm;
  import mccu_pkg::*;

  logic       clk = 1'b0, clrn = 1'b0;
  logic [5:0] op = '0, func = '0;
  logic       z = 1'b0, mem_rdy = 1'b1;
  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;
  logic [3:0] icount;

  int n_tests = 0, n_fail = 0, exp_cnt = 0;

  mccu_fsm #(.CNT_W(4)) dut (
    .clk(clk), .clrn(clrn), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
    .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord),
    .regrt(regrt), .m2reg(m2reg), .jal(jal), .shift(shift), .sext(sext),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource),
    .state(state), .icount(icount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // enables packed as {wpc,wir,wmem,wreg}
  task automatic ck_en(input string tag, input logic [3:0] e);
    chk({tag, ".en"}, {28'd0, wpc, wir, wmem, wreg}, {28'd0, e});
  endtask

  task automatic ck_st(input string tag, input int s);
    chk({tag, ".state"}, {29'd0, state}, s);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input string tag);
    exp_cnt = (exp_cnt + 1) % 16;
    ck_st(tag, 0);
    chk({tag, ".icount"}, {28'd0, icount}, exp_cnt);
  endtask

  // sif checks then advance into sid
  task automatic fetch(input string tag);
    ck_st({tag, ".if"}, 0);
    ck_en({tag, ".if"}, 4'b1100);
    chk({tag, ".if.ctl"}, {26'd0, iord, alusrca, alusrcb, pcsource}, 32'b0_0_01_00);
    step();
    ck_st({tag, ".id"}, 1);
  endtask

  // ALU-class table: op, func, aluc, alusrcb, regrt, shift, sext
  logic [5:0] t_op   [8] = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_ORI, OP_LUI, OP_ADDI};
  logic [5:0] t_fn   [8] = '{FN_ADD, FN_SUB, FN_AND, FN_XOR, FN_SRA, 6'd0, 6'd0, 6'd0};
  logic [3:0] t_aluc [8] = '{4'b0000, 4'b0100, 4'b0001, 4'b0010, 4'b1111, 4'b0101, 4'b0110, 4'b0000};
  logic [1:0] t_srcb [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10};
  logic       t_rt   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       t_sh   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       t_sx   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #2;
    ck_st("rst", 0);
    ck_en("rst", 4'b0000);
    chk("rst.icount", {28'd0, icount}, 0);
    #6 clrn = 1'b1;
    #1;
    ck_en("rel", 4'b1100);

    // R/I ALU instructions: 4 cycles
    for (int i = 0; i < 8; i++) begin
      op = t_op[i]; func = t_fn[i];
      fetch($sformatf("alu%0d", i));
      ck_en($sformatf("alu%0d.id", i), 4'b0000);
      chk($sformatf("alu%0d.id.srcb", i), {30'd0, alusrcb}, 3);
      step();
      ck_st($sformatf("alu%0d.exe", i), 2);
      ck_en($sformatf("alu%0d.exe", i), 4'b0000);
      chk($sformatf("alu%0d.exe.aluc", i), {28'd0, aluc}, {28'd0, t_aluc[i]});
      chk($sformatf("alu%0d.exe.ctl", i), {28'd0, alusrca, t_sh[i] ? shift : shift, sext, 1'b0},
          {28'd0, 1'b1, t_sh[i], t_sx[i], 1'b0});
      chk($sformatf("alu%0d.exe.srcb", i), {30'd0, alusrcb}, {30'd0, t_srcb[i]});
      step();
      ck_st($sformatf("alu%0d.wb", i), 4);
      ck_en($sformatf("alu%0d.wb", i), 4'b0001);
      chk($sformatf("alu%0d.wb.rt", i), {30'd0, regrt, m2reg}, {30'd0, t_rt[i], 1'b0});
      step();
      retire($sformatf("alu%0d.ret", i));
    end

    // lw: 5 cycles
    op = OP_LW; func = 6'd0;
    fetch("lw");
    step();
    chk("lw.exe.ctl", {28'd0, alusrcb, sext, alusrca}, 32'b10_1_1);
    step();
    ck_st("lw.mem", 3);
    chk("lw.mem.iord", {31'd0, iord}, 1);
    ck_en("lw.mem", 4'b0000);
    step();
    ck_st("lw.wb", 4);
    ck_en("lw.wb", 4'b0001);
    chk("lw.wb.ctl", {30'd0, regrt, m2reg}, 3);
    step();
    retire("lw.ret");

    // sw: 4 cycles, write only in smem
    op = OP_SW;
    fetch("sw");
    ck_en("sw.id", 4'b0000);
    step();
    ck_en("sw.exe", 4'b0000);
    step();
    ck_st("sw.mem", 3);
    ck_en("sw.mem", 4'b0010);
    step();
    retire("sw.ret");

    // branches: 3 cycles, {op, z, expected wpc}
    for (int b = 0; b < 4; b++) begin
      op = (b < 2) ? OP_BEQ : OP_BNE;
      z  = b[0];
      fetch($sformatf("br%0d", b));
      step();
      ck_st($sformatf("br%0d.exe", b), 2);
      ck_en($sformatf("br%0d.exe", b), (b == 1 || b == 2) ? 4'b1000 : 4'b0000);
      chk($sformatf("br%0d.exe.pcs", b), {30'd0, pcsource}, 1);
      chk($sformatf("br%0d.exe.aluc", b), {28'd0, aluc}, 4);
      step();
      retire($sformatf("br%0d.ret", b));
    end
    z = 1'b0;

    // jal / j / jr: 2 cycles
    op = OP_JAL;
    fetch("jal");
    ck_en("jal.id", 4'b1001);
    chk("jal.id.ctl", {29'd0, jal, pcsource}, 32'b1_11);
    step();
    retire("jal.ret");

    op = OP_J;
    fetch("j");
    ck_en("j.id", 4'b1000);
    chk("j.id.ctl", {29'd0, jal, pcsource}, 32'b0_11);
    step();
    retire("j.ret");

    op = OP_RTYPE; func = FN_JR;
    fetch("jr");
    ck_en("jr.id", 4'b1000);
    chk("jr.id.pcs", {30'd0, pcsource}, 2);
    step();
    retire("jr.ret");

    // undefined op: no writes, retired as nop
    op = 6'b111111;
    fetch("ill");
    ck_en("ill.id", 4'b0000);
    step();
    retire("ill.ret");

    // reset during sexe
    op = OP_RTYPE; func = FN_ADD;
    fetch("rmid");
    step();
    ck_st("rmid.exe", 2);
    clrn = 1'b0;
    #1;
    ck_st("rmid.rst", 0);
    ck_en("rmid.rst", 4'b0000);
    chk("rmid.icount", {28'd0, icount}, 0);
    exp_cnt = 0;
    step();
    clrn = 1'b1;
    #1;
    ck_en("rmid.rel", 4'b1100);
    ck_st("rmid.rel", 0);

`ifdef MCCU_MEMWAIT_EN
    // fetch stalls while memory is not ready
    op = OP_SW; func = 6'd0;
    mem_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ck_st($sformatf("mw.if%0d", k), 0);
      ck_en($sformatf("mw.if%0d", k), 4'b0000);
      step();
    end
    mem_rdy = 1'b1;
    fetch("mw");
    step();
    step();
    mem_rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ck_st($sformatf("mw.mem%0d", k), 3);
      ck_en($sformatf("mw.mem%0d", k), 4'b0010);
      step();
    end
    mem_rdy = 1'b1;
    ck_st("mw.memrdy", 3);
    ck_en("mw.memrdy", 4'b0010);
    step();
    retire("mw.ret");
`else
    // mem_rdy has no effect in this build
    op = OP_J; func = 6'd0;
    mem_rdy = 1'b0;
    fetch("nw");
    step();
    retire("nw.ret");
    mem_rdy = 1'b1;
`endif

    // counter wrap: 16 more jumps returns icount to its prior value
    op = OP_J;
    for (int n = 0; n < 16; n++) begin
      step();
      step();
      exp_cnt = (exp_cnt + 1) % 16;
    end
    ck_st("wrap", 0);
    chk("wrap.icount", {28'd0, icount}, exp_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
